bus_capture_fifo: RTL

//  Downstream consumer of the enable/data bus interface. Each cycle enable=1, it captures
//  the data word into a first-word-fall-through FIFO and presents it to the next stage on a

---
 rtl/bus_cap_pkg.sv | 16 +
 rtl/bus_cap_if.sv | 35 +++
 rtl/bus_cap_ram.sv | 39 +++
 rtl/bus_capture_fifo.sv | 100 ++++++++++
 4 files changed

// File: rtl/bus_cap_pkg.sv
`default_nettype none
// ============================================================================
// bus_cap_pkg : shared defaults and types for the bus capture FIFO
// Rev 1.0
// ============================================================================
package bus_cap_pkg;

   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 8;
   localparam int AW_DEF    = $clog2(DEPTH_DEF);

   typedef logic [DW_DEF-1:0] data_t;
   typedef logic [AW_DEF:0]   ptr_t;

endpackage
`default_nettype wire

// File: rtl/bus_cap_if.sv
`default_nettype none
// ============================================================================
// bus_cap_if : enable/data capture bus plus valid/ready output handshake
// Rev 1.0
// ============================================================================
interface bus_cap_if
   import bus_cap_pkg::*;
#(
   parameter int DW = DW_DEF
) ();

   logic          bus_enable;
   logic [DW-1:0] bus_data;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;

   modport master (
      output bus_enable,
      output bus_data,
      output out_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  bus_enable,
      input  bus_data,
      input  out_ready,
      output out_valid,
      output out_data
   );

endinterface
`default_nettype wire

// File: rtl/bus_cap_ram.sv
`default_nettype none
// ============================================================================
// bus_cap_ram : DEPTH x DW register array, one write port, async read port
// Rev 1.0
// ============================================================================
module bus_cap_ram
   import bus_cap_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   // Storage is deliberately left unreset; the FIFO masks it while empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/bus_capture_fifo.sv
`default_nettype none
// ============================================================================
// bus_capture_fifo : FWFT FIFO capturing enable-qualified bus words, sticky
// overflow flag; BUS_DROP_CNT_EN adds a saturating drop counter. Rev 1.0
// ============================================================================
module bus_capture_fifo
   import bus_cap_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   bus_cap_if.slave                 bus,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     overflow,
   input  logic                     clr_overflow
`ifdef BUS_DROP_CNT_EN
   ,
   output logic [15:0]              drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          overflow_q, overflow_d;
   logic          empty, push, pop, drop;
   logic [DW-1:0] ram_rdata;

   always_comb begin
      empty      = (wr_ptr_q == rd_ptr_q);
      full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop        = !empty && bus.out_ready;
      push       = bus.bus_enable && (!full || pop);
      drop       = bus.bus_enable && full && !pop;
      wr_ptr_d   = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
      // A drop in the same cycle as a clear keeps the flag set.
      overflow_d = drop | (overflow_q & ~clr_overflow);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   bus_cap_ram #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (bus.bus_data),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (ram_rdata)
   );

   assign level         = wr_ptr_q - rd_ptr_q;
   assign overflow      = overflow_q;
   assign bus.out_valid = !empty;
   assign bus.out_data  = empty ? '0 : ram_rdata;

`ifdef BUS_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (clr_overflow) begin
         drop_cnt_d = {15'd0, drop};
      end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= 16'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire
